// File: rtl/router_pkg.sv
// Shared defaults and types for the router output-channel FIFO.
package router_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int LEN_MSB_DEF = 7;
   localparam int LEN_LSB_DEF = 2;

   // One stored FIFO slot: header flag alongside the byte.
   typedef struct packed {
      logic                  hdr;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;

   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array with one write port and a registered read port.
module router_fifo_mem #(
   parameter int W     = 9,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // read stage boundary: the output register is cleared so the channel never shows stale data after a flush
   always_ff @(posedge clk) begin
      if (clear)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel, with occupancy
// flags and an end-of-packet pulse aligned to the parity byte on dataout.
module router_pkt_fifo
   import router_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = 16,
   parameter int LEN_MSB  = LEN_MSB_DEF,
   parameter int LEN_LSB  = LEN_LSB_DEF,
   parameter int AFULL_TH = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      soft_reset,
   input  logic                      write_enb,
   input  logic                      lfd_state,
   input  logic [DATA_W-1:0]         datain,
   input  logic                      read_enb,
   output logic [DATA_W-1:0]         dataout,
   output logic                      dout_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic [occ_w(DEPTH)-1:0]   occupancy,
   output logic                      pkt_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = occ_w(DEPTH);
   localparam int RW = LEN_MSB - LEN_LSB + 2;

   logic            clear;
   logic            wr_acc;
   logic            rd_acc;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [OW-1:0]   occ_cnt;
   logic [RW-1:0]   rem;
   logic [DATA_W:0] wr_entry;
   logic [DATA_W:0] rd_entry;
   logic            rd_hdr;
   logic [RW-2:0]   rd_len;

   assign clear    = !resetn || soft_reset;
   assign wr_acc   = write_enb && !full;
   assign rd_acc   = read_enb && !empty;
   assign wr_entry = {lfd_state, datain};

   assign full        = (occ_cnt == OW'(DEPTH));
   assign empty       = (occ_cnt == '0);
   assign almost_full = (occ_cnt >= OW'(AFULL_TH));
   assign occupancy   = occ_cnt;

   router_fifo_mem #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .clear   (clear),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   assign dataout = rd_entry[DATA_W-1:0];
   assign rd_hdr  = rd_entry[DATA_W];
   assign rd_len  = rd_entry[LEN_MSB:LEN_LSB];

   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ_cnt <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   occ_cnt <= occ_cnt + OW'(1);
            2'b01:   occ_cnt <= occ_cnt - OW'(1);
            default: occ_cnt <= occ_cnt;
         endcase
      end
   end

   // output stage boundary: rem trails the byte on dataout, so pkt_done is decoded
   // from the displayed entry and rem is advanced one edge later
   always_ff @(posedge clk) begin
      if (clear) begin
         dout_valid <= 1'b0;
         rem        <= '0;
      end else begin
         dout_valid <= rd_acc;
         if (dout_valid) begin
            if (rd_hdr)          rem <= {1'b0, rd_len} + RW'(1);
            else if (rem != '0)  rem <= rem - RW'(1);
         end
      end
   end

   assign pkt_done = dout_valid && !rd_hdr && (rem == RW'(1));

endmodule
